// File: rtl/aes_key_schedule.sv
// aes_key_schedule: iterative AES-128 round-key generator, 0->10 walk; reverse 10->0 walk compiled in by AES_INV_KEY_EN
module aes_key_schedule (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         encrypt,
  input  logic [127:0] key_in,
  output logic [127:0] round_key,
  output logic [3:0]   round_num,
  output logic         key_valid,
  input  logic         key_ready,
  output logic         busy,
  output logic         done
);
  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;
  localparam logic [2047:0] sbox_lut = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  localparam logic [127:0] rcon_lut = 128'h0000000000361b804020100804020100;
  state_t state_q, state_d;
  logic [127:0] key_q, key_d, fwd_key, nxt_key;
  logic [3:0] rnd_q, rnd_d;
  logic load, xfer, last, fwd, start_fwd;
  logic [31:0] t;
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return sbox_lut[11'd2047 - {x, 3'b000} -: 8];
  endfunction
  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction
  function automatic logic [7:0] rcon(input logic [3:0] r);
    return rcon_lut[{r, 3'b000} +: 8];
  endfunction
  assign load = state_q != EMIT && start;
  assign xfer = state_q == EMIT && key_ready;
  assign last = fwd ? rnd_q == 4'd10 : rnd_q == 4'd0;
  assign t = sub_rot(key_q[31:0]) ^ {rcon(rnd_q + 4'd1), 24'h0};
  assign fwd_key[127:96] = key_q[127:96] ^ t;
  assign fwd_key[95:64] = key_q[95:64] ^ fwd_key[127:96];
  assign fwd_key[63:32] = key_q[63:32] ^ fwd_key[95:64];
  assign fwd_key[31:0] = key_q[31:0] ^ fwd_key[63:32];
`ifdef AES_INV_KEY_EN
  logic fwd_q, fwd_d;
  logic [127:0] inv_key;
  assign inv_key[31:0] = key_q[31:0] ^ key_q[63:32];
  assign inv_key[63:32] = key_q[63:32] ^ key_q[95:64];
  assign inv_key[95:64] = key_q[95:64] ^ key_q[127:96];
  assign inv_key[127:96] = key_q[127:96] ^ sub_rot(inv_key[31:0]) ^ {rcon(rnd_q), 24'h0};
  assign start_fwd = encrypt;
  assign fwd_d = load ? encrypt : fwd_q;
  assign fwd = fwd_q;
  assign nxt_key = fwd_q ? fwd_key : inv_key;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fwd_q <= 1'b1;
    else fwd_q <= fwd_d;
  end
`else
  logic unused_encrypt;
  assign unused_encrypt = encrypt;
  assign start_fwd = 1'b1;
  assign fwd = 1'b1;
  assign nxt_key = fwd_key;
`endif
  always_comb begin
    state_d = state_q;
    key_d = key_q;
    rnd_d = rnd_q;
    if (load) begin
      key_d = key_in;
      rnd_d = start_fwd ? 4'd0 : 4'd10;
      state_d = EMIT;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else if (xfer) begin
      state_d = last ? DONE : EMIT;
      key_d = last ? key_q : nxt_key;
      rnd_d = last ? rnd_q : (fwd ? rnd_q + 4'd1 : rnd_q - 4'd1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q <= '0;
      rnd_q <= '0;
    end else begin
      state_q <= state_d;
      key_q <= key_d;
      rnd_q <= rnd_d;
    end
  end
  assign round_key = key_q;
  assign round_num = rnd_q;
  assign key_valid = state_q == EMIT;
  assign busy = state_q == EMIT;
  assign done = state_q == DONE;
endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Iterative AES-128 key-expansion unit that supplies one 128-bit round key per handshake to the round datapath, including the `keyword` input of the final round stage. It loads a key on `start` and then steps through the schedule, producing round keys 0..10 in order. It needs no key RAM, because each next key is computed from the current one with a single SubWord. An optional inverse schedule walks from round 10 back to round 0 for decryption.

## Interface
Parameters:
- none (AES-128 only; key width fixed at 128)

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  load `key_in` and begin a schedule; honoured only when `busy`=0
- `encrypt`  in  1  sampled with `start`: 1 = forward order (0→10), 0 = reverse order (10→0)
- `key_in`  in  128  cipher key (encrypt) or round-10 key (decrypt); bits [127:96] = w0, byte 0 = MSB
- `round_key`  out  128  current round key; stable while `key_valid`=1
- `round_num`  out  4  index of `round_key`, 0..10
- `key_valid`  out  1  `round_key` is valid
- `key_ready`  in  1  consumer accepts the key; transfer occurs when `key_valid` & `key_ready`
- `busy`  out  1  schedule in progress
- `done`  out  1  one-cycle pulse after the final key is transferred

## Operation
- FSM states are IDLE, EMIT and DONE.
- **IDLE:**
  - On `start`, register `key_in` into the key register.
  - Latch mode from `encrypt`.
  - Set `round_num` to 0 (forward) or 10 (reverse).
  - Set `key_valid`=1 and `busy`=1, then go to EMIT.
- **EMIT:**
  - On transfer, the key register is loaded with the next key and `round_num` steps by ±1.
  - `key_valid` stays 1.
  - A transfer of the last key (10 forward, 0 reverse) instead sets `key_valid`=0 and moves to DONE.
  - With `key_ready`=0, all outputs hold.
- **DONE:** `done`=1 and `busy`=0 for one cycle, then go to IDLE.
- **Forward step**, producing key r from key r−1 (words w0..w3):
  - t = SubWord(RotWord(w3)) ^ {Rcon[r],24'h0}
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'
- **Inverse step**, producing key r−1 from key r:
  - w3 = w3'^w2'; w2 = w2'^w1'; w1 = w1'^w0'
  - w0 = w0' ^ SubWord(RotWord(w3)) ^ {Rcon[r],24'h0}
- RotWord{b0,b1,b2,b3} = {b1,b2,b3,b0}.
- SubWord uses the team's existing forward S-box substitution, applied to 4 bytes.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- All XOR arithmetic is 128-bit; there are no carries.
- `start` while `busy`=1 is ignored; the schedule is not restarted.

## Timing
- **Reset values:**
  - `round_key`=0, `round_num`=0
  - `key_valid`=0, `busy`=0, `done`=0
  - FSM in IDLE
- **Reset mid-schedule:** all outputs clear immediately (asynchronous). There is no resume after reset.
- **Start:** `start` sampled at edge t gives first key valid at t+1.
- **Throughput:** with `key_ready` held 1, key k (forward) appears at t+1+k, round 10 at t+11, and the `done` pulse at t+12. Each stall cycle delays all later events by one.
- **Next-key logic:** combinational from the key register. It is a single S-box level plus XOR chain, and completes in one cycle.
- **Start in the `done` cycle:** `start` is accepted at the edge ending the DONE cycle. The next schedule's key 0/10 is valid one cycle after that edge.
- **Mode sampling:** `encrypt` is ignored except at the cycle `start` is accepted.

## Configuration
- Macro: `AES_INV_KEY_EN`.
- **Defined:**
  - Inverse-step logic and reverse counting are compiled in.
  - `encrypt`=0 selects the 10→0 walk.
- **Undefined:**
  - The inverse logic is absent and `encrypt` is ignored.
  - Every schedule runs forward 0→10, and `key_in` is always treated as the cipher key.

## Test plan
- **Forward sequence.** Reset, then `start`, `encrypt`=1, `key_in`=2b7e151628aed2a6abf7158809cf4f3c, `key_ready`=1. Required:
  - round 0 equals `key_in`
  - round 1 = a0fafe1788542cb123a339392a6c7605
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6
  - `done` pulse at t+12
- **Reverse sequence** (`AES_INV_KEY_EN` defined). `start`, `encrypt`=0, `key_in`=d014f9a8c9ee2589e13f0cc8b6630ca6. Required:
  - `round_num` counts 10→0
  - round 1 = a0fafe17…2a6c7605
  - round 0 = 2b7e1516…09cf4f3c
- **Backpressure.** Toggle `key_ready` pseudo-randomly. Required:
  - `round_key` and `round_num` are unchanged on every stalled cycle
  - keys are identical to the unstalled run
  - there are exactly 11 transfers
- **Start while busy.** Pulse `start` with a different key at round 4. Required: ignored, and the sequence completes with the original key.
- **Reset mid-operation.** Deassert `rst_n` at round 6. Required:
  - all outputs 0 asynchronously
  - a new `start` after release yields round 0 one cycle later
- **Back-to-back.** Assert `start` in the `done` cycle. Required: second schedule's first key valid one cycle after that edge, with correct values.
